// File: rtl/resp_chk_pkg.sv
// Shared types and helpers for the response checker: FSM state encoding,
// counter width and a saturating increment.
package resp_chk_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/resp_checker_if.sv
// Expected-value push stream and observed-value stream between a bench
// driver (master) and the response checker (slave).
interface resp_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;

    modport master (
        output exp_valid, exp_data, obs_valid, obs_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_data, obs_valid, obs_data,
        output exp_ready
    );
endinterface

// File: rtl/resp_fifo.sv
// Synchronous FIFO holding expected values; no write-to-read bypass, so an
// entry written at edge N is first visible at the head after that edge.
module resp_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage is not reset; only occupancy decides what is readable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/resp_checker.sv
// Response checker: queues expected values, compares each accepted observation
// against the queue head one cycle later, and reports a registered verdict.
module resp_checker
    import resp_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    resp_checker_if.slave     bus,
    input  logic              start,
    input  logic [7:0]        num_vec,
    output logic              mismatch,
    output logic [WIDTH-1:0]  mis_exp,
    output logic [WIDTH-1:0]  mis_obs,
    output logic [CNT_W-1:0]  err_count,
    output logic              underflow,
    output logic              timeout,
    output logic              done,
    output logic              pass
);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    logic [7:0]       r_total;
    logic [7:0]       r_checked;
    logic [IW-1:0]    r_idle;
    logic             r_cmp_valid;
    logic             r_cmp_uf;
    logic [WIDTH-1:0] r_cmp_exp;
    logic [WIDTH-1:0] r_cmp_obs;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_mis_exp;
    logic [WIDTH-1:0] r_mis_obs;
    logic [CNT_W-1:0] r_err_count;
    logic             r_underflow;
    logic             r_timeout;
    logic             r_done;
    logic             r_pass;

    logic [WIDTH-1:0] w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_all_seen;
    logic             w_accept;
    logic             w_pop;

    resp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.exp_valid),
        .i_data  (bus.exp_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A start pulse wins over a coincident observation: the run restarts clean.
    assign w_all_seen    = (r_checked == r_total);
    assign w_accept      = (r_state == ST_RUN) && bus.obs_valid && !start && !w_all_seen;
    assign w_pop         = w_accept && !w_fifo_empty;
    assign bus.exp_ready = !w_fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_total     <= '0;
            r_checked   <= '0;
            r_idle      <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_uf    <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_obs   <= '0;
            r_mismatch  <= 1'b0;
            r_mis_exp   <= '0;
            r_mis_obs   <= '0;
            r_err_count <= '0;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_mismatch  <= 1'b0;
            r_cmp_valid <= w_accept;
            if (w_accept) begin
                r_cmp_uf  <= w_fifo_empty;
                r_cmp_exp <= w_head;
                r_cmp_obs <= bus.obs_data;
            end

            if (start) begin
                r_total     <= num_vec;
                r_checked   <= '0;
                r_idle      <= '0;
                r_err_count <= '0;
                r_underflow <= 1'b0;
                r_timeout   <= 1'b0;
                if (num_vec == 8'd0) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_pass  <= 1'b1;
                end else begin
                    r_state <= ST_RUN;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            end else begin
                // Second stage: publish the result of last cycle's observation.
                if (r_cmp_valid) begin
                    if (r_cmp_uf) begin
                        r_underflow <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                    end else if (r_cmp_exp != r_cmp_obs) begin
                        r_mismatch  <= 1'b1;
                        r_mis_exp   <= r_cmp_exp;
                        r_mis_obs   <= r_cmp_obs;
                        r_err_count <= sat_inc(r_err_count);
                    end
                end

                case (r_state)
                    ST_RUN: begin
                        if (w_accept) begin
                            r_checked <= r_checked + 8'd1;
                            r_idle    <= '0;
                        end else if (w_all_seen) begin
                            // Wait for the final compare to land before the verdict.
                            if (!r_cmp_valid) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_pass  <= (r_err_count == '0);
                            end
                        end else if (r_idle == IW'(TIMEOUT - 1)) begin
                            r_state   <= ST_DONE;
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_pass    <= 1'b0;
                        end else begin
                            r_idle <= r_idle + IW'(1);
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign mismatch  = r_mismatch;
    assign mis_exp   = r_mis_exp;
    assign mis_obs   = r_mis_obs;
    assign err_count = r_err_count;
    assign underflow = r_underflow;
    assign timeout   = r_timeout;
    assign done      = r_done;
    assign pass      = r_pass;

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: directed scenarios with fixed expectations, then
// randomized runs checked against a queue-based behavioural model.
module tb_resp_checker;
    import resp_chk_pkg::*;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       num_vec = '0;
    logic             mismatch;
    logic [WIDTH-1:0] mis_exp;
    logic [WIDTH-1:0] mis_obs;
    logic [7:0]       err_count;
    logic             underflow;
    logic             timeout;
    logic             done;
    logic             pass;

    always #5 clk = ~clk;

    resp_checker_if #(.WIDTH(WIDTH)) bus ();

    resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .num_vec(num_vec),
        .mismatch(mismatch), .mis_exp(mis_exp), .mis_obs(mis_obs), .err_count(err_count),
        .underflow(underflow), .timeout(timeout), .done(done), .pass(pass)
    );

    int total_n = 0;
    int bad_n   = 0;
    bit mm_seen = 0;

    // Behavioural model: expected queue, run bookkeeping, predicted outputs.
    int q[$];
    bit m_run;
    int m_total, m_checked, m_idle;
    bit pend_v, pend_uf;
    int pend_e, pend_o;
    bit e_mm, e_uf, e_to, e_done, e_pass;
    int e_err, e_mis_exp, e_mis_obs;

    task automatic model_reset();
        q.delete();
        m_run = 0; m_total = 0; m_checked = 0; m_idle = 0;
        pend_v = 0; pend_uf = 0; pend_e = 0; pend_o = 0;
        e_mm = 0; e_uf = 0; e_to = 0; e_done = 0; e_pass = 0;
        e_err = 0; e_mis_exp = 0; e_mis_obs = 0;
    endtask

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        bit st, pv, ov, acc, pushok, old_pv;
        int nv, pd, od;
        st = start; nv = int'(num_vec);
        pv = bus.exp_valid; pd = int'(bus.exp_data);
        ov = bus.obs_valid; od = int'(bus.obs_data);
        acc    = m_run && ov && !st && (m_checked < m_total);
        pushok = pv && (q.size() < DEPTH);
        @(posedge clk);
        #1;
        if (mismatch) mm_seen = 1;
        old_pv = pend_v;
        pend_v = 0;
        e_mm   = 0;
        if (st) begin
            m_total = nv; m_checked = 0; m_idle = 0;
            e_err = 0; e_uf = 0; e_to = 0;
            m_run = (nv != 0); e_done = (nv == 0); e_pass = (nv == 0);
        end else begin
            if (old_pv) begin
                if (pend_uf) begin
                    e_uf = 1; if (e_err < 255) e_err++;
                end else if (pend_e != pend_o) begin
                    e_mm = 1; e_mis_exp = pend_e; e_mis_obs = pend_o;
                    if (e_err < 255) e_err++;
                end
            end
            if (m_run) begin
                if (acc) begin
                    pend_v = 1; pend_o = od;
                    if (q.size() > 0) begin pend_uf = 0; pend_e = q.pop_front(); end
                    else pend_uf = 1;
                    m_checked++; m_idle = 0;
                end else if (m_checked == m_total) begin
                    if (!old_pv) begin m_run = 0; e_done = 1; e_pass = (e_err == 0); end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin m_run = 0; e_to = 1; e_done = 1; e_pass = 0; end
                end
            end
        end
        if (pushok) q.push_back(pd);
    endtask

    task automatic drive(input logic pv, input logic [3:0] pd, input logic ov,
                         input logic [3:0] od, input logic st, input logic [7:0] nv);
        bus.exp_valid = pv; bus.exp_data = pd;
        bus.obs_valid = ov; bus.obs_data = od;
        start = st; num_vec = nv;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'h0, 0, 4'h0, 0, 8'd0);
    endtask

    task automatic test_reset();
        bus.exp_valid = 0; bus.exp_data = '0; bus.obs_valid = 0; bus.obs_data = '0;
        model_reset();
        #22;
        total_n++; if ({mismatch, underflow, timeout, done, pass} !== 5'b0) begin bad_n++;
            $display("FAIL reset_flags got=%b want=00000", {mismatch, underflow, timeout, done, pass}); end
        total_n++; if ({err_count, mis_exp, mis_obs} !== 16'h0) begin bad_n++;
            $display("FAIL reset_values got=%h want=0000", {err_count, mis_exp, mis_obs}); end
        total_n++; if (bus.exp_ready !== 1'b1) begin bad_n++;
            $display("FAIL reset_exp_ready got=%b want=1", bus.exp_ready); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_single_pass();
        mm_seen = 0;
        drive(1, 4'b0101, 0, 4'h0, 0, 8'd0);
        drive(0, 4'h0, 0, 4'h0, 1, 8'd1);
        drive(0, 4'h0, 1, 4'b0101, 0, 8'd0);
        idle(1);
        total_n++; if (done !== 1'b0) begin bad_n++;
            $display("FAIL single_done_early got=%b want=0", done); end
        idle(1);
        total_n++; if ({done, pass, err_count, mm_seen} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin bad_n++;
            $display("FAIL single_pass done=%b pass=%b err=%0d mm=%b want 1 1 0 0", done, pass, err_count, mm_seen); end
    endtask

    task automatic test_mismatch();
        drive(1, 4'b0101, 0, 4'h0, 0, 8'd0);
        drive(1, 4'b1010, 0, 4'h0, 0, 8'd0);
        drive(0, 4'h0, 0, 4'h0, 1, 8'd2);
        drive(0, 4'h0, 1, 4'b0100, 0, 8'd0);
        drive(0, 4'h0, 1, 4'b1010, 0, 8'd0);
        total_n++; if ({mismatch, mis_exp, mis_obs, err_count} !== {1'b1, 4'b0101, 4'b0100, 8'd1}) begin bad_n++;
            $display("FAIL mismatch_capture mm=%b exp=%b obs=%b err=%0d want 1 0101 0100 1",
                     mismatch, mis_exp, mis_obs, err_count); end
        idle(1);
        total_n++; if ({mismatch, err_count, done} !== {1'b0, 8'd1, 1'b0}) begin bad_n++;
            $display("FAIL mismatch_second mm=%b err=%0d done=%b want 0 1 0", mismatch, err_count, done); end
        idle(1);
        total_n++; if ({done, pass, err_count} !== {1'b1, 1'b0, 8'd1}) begin bad_n++;
            $display("FAIL mismatch_verdict done=%b pass=%b err=%0d want 1 0 1", done, pass, err_count); end
    endtask

    task automatic test_full_fifo();
        mm_seen = 0;
        for (int i = 1; i <= 8; i++) drive(1, 4'(i), 0, 4'h0, 0, 8'd0);
        total_n++; if (bus.exp_ready !== 1'b0) begin bad_n++;
            $display("FAIL full_ready got=%b want=0", bus.exp_ready); end
        drive(1, 4'd9, 0, 4'h0, 0, 8'd0);
        drive(0, 4'h0, 0, 4'h0, 1, 8'd9);
        drive(1, 4'hE, 1, 4'd1, 0, 8'd0);
        total_n++; if (bus.exp_ready !== 1'b1) begin bad_n++;
            $display("FAIL full_pop_ready got=%b want=1", bus.exp_ready); end
        drive(1, 4'hC, 1, 4'd2, 0, 8'd0);
        total_n++; if (bus.exp_ready !== 1'b1) begin bad_n++;
            $display("FAIL simul_ready got=%b want=1", bus.exp_ready); end
        for (int i = 3; i <= 8; i++) drive(0, 4'h0, 1, 4'(i), 0, 8'd0);
        drive(0, 4'h0, 1, 4'hC, 0, 8'd0);
        idle(2);
        total_n++; if ({done, pass, err_count, underflow, mm_seen} !== {1'b1, 1'b1, 8'd0, 1'b0, 1'b0}) begin bad_n++;
            $display("FAIL full_order done=%b pass=%b err=%0d uf=%b mm=%b want 1 1 0 0 0",
                     done, pass, err_count, underflow, mm_seen); end
    endtask

    task automatic test_underflow();
        drive(0, 4'h0, 0, 4'h0, 1, 8'd1);
        drive(0, 4'h0, 1, 4'b0011, 0, 8'd0);
        idle(1);
        total_n++; if ({underflow, err_count, mismatch} !== {1'b1, 8'd1, 1'b0}) begin bad_n++;
            $display("FAIL underflow_flag uf=%b err=%0d mm=%b want 1 1 0", underflow, err_count, mismatch); end
        idle(1);
        total_n++; if ({done, pass} !== 2'b10) begin bad_n++;
            $display("FAIL underflow_verdict done=%b pass=%b want 1 0", done, pass); end
    endtask

    task automatic test_timeout();
        drive(1, 4'h6, 0, 4'h0, 0, 8'd0);
        drive(0, 4'h0, 0, 4'h0, 1, 8'd3);
        drive(0, 4'h0, 1, 4'h6, 0, 8'd0);
        idle(TIMEOUT - 1);
        total_n++; if ({done, timeout} !== 2'b00) begin bad_n++;
            $display("FAIL timeout_early done=%b to=%b want 0 0", done, timeout); end
        idle(1);
        total_n++; if ({timeout, done, pass, err_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin bad_n++;
            $display("FAIL timeout_verdict to=%b done=%b pass=%b err=%0d want 1 1 0 0",
                     timeout, done, pass, err_count); end
    endtask

    task automatic test_zero_vec();
        drive(0, 4'h0, 1, 4'h1, 1, 8'd0);
        total_n++; if ({done, pass, timeout, err_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin bad_n++;
            $display("FAIL zero_vec done=%b pass=%b to=%b err=%0d want 1 1 0 0", done, pass, timeout, err_count); end
    endtask

    task automatic test_reset_midrun();
        for (int i = 10; i < 14; i++) drive(1, 4'(i), 0, 4'h0, 0, 8'd0);
        drive(0, 4'h0, 0, 4'h0, 1, 8'd5);
        drive(0, 4'h0, 1, 4'h0, 0, 8'd0);
        idle(1);
        #1 rst_n = 0;
        #1;
        total_n++; if ({mismatch, err_count, mis_exp, mis_obs, underflow, timeout, done, pass, bus.exp_ready}
                       !== {1'b0, 8'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin bad_n++;
            $display("FAIL midrun_reset mm=%b err=%0d exp=%h obs=%h done=%b rdy=%b want 0 0 0 0 0 1",
                     mismatch, err_count, mis_exp, mis_obs, done, bus.exp_ready); end
        model_reset();
        @(negedge clk); rst_n = 1;
        drive(0, 4'h0, 0, 4'h0, 1, 8'd1);
        drive(0, 4'h0, 1, 4'h7, 0, 8'd0);
        idle(1);
        total_n++; if ({underflow, err_count} !== {1'b1, 8'd1}) begin bad_n++;
            $display("FAIL midrun_flushed uf=%b err=%0d want 1 1", underflow, err_count); end
        idle(1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            int pre, nv, pick, p_obs, n;
            logic push_b, obs_b;
            logic [3:0] od;
            pre = $urandom_range(0, 6);
            nv = $urandom_range(1, 10);
            pick = $urandom_range(0, 3);
            p_obs = (pick == 0) ? 0 : (pick == 1) ? 30 : (pick == 2) ? 70 : 100;
            for (int i = 0; i < pre; i++) drive(1, 4'($urandom), 0, 4'h0, 0, 8'd0);
            drive(0, 4'h0, 0, 4'h0, 1, 8'(nv));
            n = 0;
            while (!e_done && n < 200) begin
                push_b = ($urandom_range(0, 99) < 30);
                obs_b = ($urandom_range(0, 99) < p_obs);
                od = (q.size() > 0 && $urandom_range(0, 1) == 1) ? 4'(q[0]) : 4'($urandom);
                drive(push_b, 4'($urandom), obs_b, od, 0, 8'd0);
                total_n++; if ({mismatch, done, err_count} !== {e_mm, e_done, 8'(e_err)}) begin bad_n++;
                    $display("FAIL rand_cycle run=%0d cyc=%0d mm=%b done=%b err=%0d want %b %b %0d",
                             r, n, mismatch, done, err_count, e_mm, e_done, e_err); end
                total_n++; if (bus.exp_ready !== (q.size() < DEPTH)) begin bad_n++;
                    $display("FAIL rand_ready run=%0d cyc=%0d got=%b want=%b", r, n, bus.exp_ready, q.size() < DEPTH); end
                if (e_mm) begin
                    total_n++; if ({mis_exp, mis_obs} !== {4'(e_mis_exp), 4'(e_mis_obs)}) begin bad_n++;
                        $display("FAIL rand_capture run=%0d exp=%h obs=%h want %h %h", r, mis_exp, mis_obs, e_mis_exp, e_mis_obs); end
                end
                n++;
            end
            total_n++; if (!e_done) begin bad_n++;
                $display("FAIL rand_bound run=%0d model never finished within 200 cycles", r); end
            total_n++; if ({pass, underflow, timeout} !== {e_pass, e_uf, e_to}) begin bad_n++;
                $display("FAIL rand_verdict run=%0d pass=%b uf=%b to=%b want %b %b %b",
                         r, pass, underflow, timeout, e_pass, e_uf, e_to); end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_mismatch();
        test_full_fifo();
        test_underflow();
        test_timeout();
        test_zero_vec();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
